// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus CPU datapath: bus width and
// the 5-bit ALU opcode encodings used by the control unit.
package data_path_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU for the datapath.
// Ports:
//   a      - operand A (register Y)
//   b      - operand B (bus value); b[4:0] is the shift/rotate amount
//   op     - opcode (see data_path_pkg)
//   result - 64-bit {hi, lo}; hi only non-zero for MUL and DIV
module alu
  import data_path_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          op,
  output logic [2*DATA_W-1:0] result
);

  logic [4:0]                  sh;
  logic [2*DATA_W-1:0]         dbl;
  logic [2*DATA_W-1:0]         ror_t;
  logic [2*DATA_W-1:0]         rol_t;
  logic signed [2*DATA_W-1:0]  prod;
  logic signed [DATA_W-1:0]    quo;
  logic signed [DATA_W-1:0]    rem;

  assign sh  = b[4:0];
  // Rotates are taken as a window into A concatenated with itself.
  assign dbl   = {a, a};
  assign ror_t = dbl >> sh;
  assign rol_t = dbl << sh;
  assign prod  = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
                 $signed({{DATA_W{b[DATA_W-1]}}, b});

  always_comb begin
    quo = '0;
    rem = '0;
    if (b != '0) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result[DATA_W-1:0] = a + b;
      OP_SUB:  result[DATA_W-1:0] = a - b;
      OP_AND:  result[DATA_W-1:0] = a & b;
      OP_OR:   result[DATA_W-1:0] = a | b;
      OP_SHR:  result[DATA_W-1:0] = a >> sh;
      OP_SHRA: result[DATA_W-1:0] = $signed(a) >>> sh;
      OP_SHL:  result[DATA_W-1:0] = a << sh;
      OP_NOT:  result[DATA_W-1:0] = ~a;
      OP_NEG:  result[DATA_W-1:0] = '0 - a;
      OP_ROR:  result[DATA_W-1:0] = ror_t[DATA_W-1:0];
      OP_ROL:  result[DATA_W-1:0] = rol_t[2*DATA_W-1:DATA_W];
      OP_MUL:  result = prod;
      OP_DIV:  result = {rem, quo};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_path.sv
// 32-bit single-bus CPU datapath: R0-R15, HI, LO, PC, InPort, Y, Zhigh/Zlow,
// MDR, a priority bus multiplexer and a combinational ALU (A = Y, B = bus).
// Ports:
//   Clock, clear          - clock and synchronous active-high reset
//   Read, Mdatain         - MDR source select and memory data
//   op                    - ALU opcode
//   *out                  - bus-drive selects (R0 highest priority, Y lowest)
//   *in, InPC             - register load enables
//   BusOut, mdrData       - bus value and MDR contents
//   BusMuxIn*             - register contents for observation
module data_path
  import data_path_pkg::*;
(
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
  input  logic R0in,   R1in,   R2in,   R3in,   R4in,   R5in,   R6in,   R7in,
  input  logic R8in,   R9in,   R10in,  R11in,  R12in,  R13in,  R14in,  R15in,
  input  logic HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin,
  output logic [DATA_W-1:0] BusOut,
  output logic [DATA_W-1:0] mdrData,
  output logic [DATA_W-1:0] BusMuxInR0,  BusMuxInR1,  BusMuxInR2,  BusMuxInR3,
  output logic [DATA_W-1:0] BusMuxInR4,  BusMuxInR5,  BusMuxInR6,  BusMuxInR7,
  output logic [DATA_W-1:0] BusMuxInR8,  BusMuxInR9,  BusMuxInR10, BusMuxInR11,
  output logic [DATA_W-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [DATA_W-1:0] BusMuxInZhigh,
  output logic [DATA_W-1:0] BusMuxInZlow,
  output logic [DATA_W-1:0] BusMuxInPCout,
  output logic [DATA_W-1:0] BusMuxInInPortout,
  output logic [DATA_W-1:0] BusMuxInYout,
  output logic [DATA_W-1:0] BusMuxInHI,
  output logic [DATA_W-1:0] BusMuxInLO
);

  logic [DATA_W-1:0]   r [16];
  logic [DATA_W-1:0]   hi, lo, pc, inport, y, zhigh, zlow, mdr;
  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_res;
  logic [15:0]         r_out;
  logic [15:0]         r_in;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // Lowest-priority source is applied first so each later, higher-priority
  // select overrides it; R0 is applied last and therefore wins.
  always_comb begin
    bus = '0;
    if (Yout)      bus = y;
    if (InPortout) bus = inport;
    if (MDRout)    bus = mdr;
    if (PCout)     bus = pc;
    if (Zlowout)   bus = zlow;
    if (Zhighout)  bus = zhigh;
    if (LOout)     bus = lo;
    if (HIOut)     bus = hi;
    for (int unsigned i = 0; i < 16; i++) begin
      if (r_out[15-i]) bus = r[15-i];
    end
  end

  alu u_alu (
    .a      (y),
    .b      (bus),
    .op     (op),
    .result (alu_res)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < 16; i++) r[i] <= '0;
      hi     <= '0;
      lo     <= '0;
      pc     <= '0;
      inport <= '0;
      y      <= '0;
      zhigh  <= '0;
      zlow   <= '0;
      mdr    <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (r_in[i]) r[i] <= bus;
      end
      if (HIin)     hi     <= bus;
      if (LOin)     lo     <= bus;
      if (InPC)     pc     <= bus;
      if (InPortin) inport <= bus;
      if (Yin)      y      <= bus;
      if (ZHighin)  zhigh  <= alu_res[2*DATA_W-1:DATA_W];
      if (Zlowin)   zlow   <= alu_res[DATA_W-1:0];
      if (MDRin)    mdr    <= Read ? Mdatain : bus;
    end
  end

  assign BusOut            = bus;
  assign mdrData           = mdr;
  assign BusMuxInR0        = r[0];
  assign BusMuxInR1        = r[1];
  assign BusMuxInR2        = r[2];
  assign BusMuxInR3        = r[3];
  assign BusMuxInR4        = r[4];
  assign BusMuxInR5        = r[5];
  assign BusMuxInR6        = r[6];
  assign BusMuxInR7        = r[7];
  assign BusMuxInR8        = r[8];
  assign BusMuxInR9        = r[9];
  assign BusMuxInR10       = r[10];
  assign BusMuxInR11       = r[11];
  assign BusMuxInR12       = r[12];
  assign BusMuxInR13       = r[13];
  assign BusMuxInR14       = r[14];
  assign BusMuxInR15       = r[15];
  assign BusMuxInZhigh     = zhigh;
  assign BusMuxInZlow      = zlow;
  assign BusMuxInPCout     = pc;
  assign BusMuxInInPortout = inport;
  assign BusMuxInYout      = y;
  assign BusMuxInHI        = hi;
  assign BusMuxInLO        = lo;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

  localparam int C_HI = 16, C_LO = 17, C_ZH = 18, C_ZL = 19;
  localparam int C_PC = 20, C_MDR = 21, C_IN = 22, C_Y = 23;

  logic        Clock, clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic [15:0] rout, rin;
  logic HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
  logic HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin;
  logic [31:0] BusOut, mdrData;
  logic [31:0] bmr [16];
  logic [31:0] BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout;
  logic [31:0] BusMuxInYout, BusMuxInHI, BusMuxInLO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m [24];

  data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .InPC(InPC), .MDRin(MDRin), .InPortin(InPortin), .Yin(Yin),
    .BusOut(BusOut), .mdrData(mdrData),
    .BusMuxInR0(bmr[0]),   .BusMuxInR1(bmr[1]),   .BusMuxInR2(bmr[2]),
    .BusMuxInR3(bmr[3]),   .BusMuxInR4(bmr[4]),   .BusMuxInR5(bmr[5]),
    .BusMuxInR6(bmr[6]),   .BusMuxInR7(bmr[7]),   .BusMuxInR8(bmr[8]),
    .BusMuxInR9(bmr[9]),   .BusMuxInR10(bmr[10]), .BusMuxInR11(bmr[11]),
    .BusMuxInR12(bmr[12]), .BusMuxInR13(bmr[13]), .BusMuxInR14(bmr[14]),
    .BusMuxInR15(bmr[15]),
    .BusMuxInZhigh(BusMuxInZhigh), .BusMuxInZlow(BusMuxInZlow),
    .BusMuxInPCout(BusMuxInPCout), .BusMuxInInPortout(BusMuxInInPortout),
    .BusMuxInYout(BusMuxInYout), .BusMuxInHI(BusMuxInHI), .BusMuxInLO(BusMuxInLO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observed register contents by register code.
  function automatic logic [31:0] obs(int c);
    if (c < 16) return bmr[c];
    case (c)
      C_HI:    return BusMuxInHI;
      C_LO:    return BusMuxInLO;
      C_ZH:    return BusMuxInZhigh;
      C_ZL:    return BusMuxInZlow;
      C_PC:    return BusMuxInPCout;
      C_MDR:   return mdrData;
      C_IN:    return BusMuxInInPortout;
      C_Y:     return BusMuxInYout;
      default: return 32'h0;
    endcase
  endfunction

  // Reference ALU computed arithmetically from the opcode definitions.
  function automatic logic [63:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [4:0] o);
    longint sa, sb, p, q, r;
    logic [31:0] t;
    int unsigned s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b) & 31;
    p  = longint'(1) << s;
    case (o)
      5'd1:  return {32'h0, a + b};
      5'd2:  return {32'h0, a - b};
      5'd3:  return {32'h0, a & b};
      5'd4:  return {32'h0, a | b};
      5'd5: begin q = longint'({32'h0, a}) / p; return {32'h0, q[31:0]}; end
      5'd6: begin
        q = sa / p;
        if (sa < 0 && q * p != sa) q = q - 1;
        return {32'h0, q[31:0]};
      end
      5'd7: begin q = longint'({32'h0, a}) * p; return {32'h0, q[31:0]}; end
      5'd8:  return {32'h0, ~a};
      5'd9: begin q = -sa; return {32'h0, q[31:0]}; end
      5'd10: begin t = a; repeat (s) t = {t[0], t[31:1]}; return {32'h0, t}; end
      5'd11: begin t = a; repeat (s) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'd12: begin q = sa * sb; return q; end
      5'd13: begin
        if (sb == 0) return 64'h0;
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle();
    rout = '0; rin = '0; Read = 1'b0; op = '0;
    {HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout} = '0;
    {HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin} = '0;
  endtask

  task automatic set_out(int c);
    if (c >= 0 && c < 16) rout[c] = 1'b1;
    case (c)
      C_HI: HIOut = 1'b1;     C_LO: LOout = 1'b1;
      C_ZH: Zhighout = 1'b1;  C_ZL: Zlowout = 1'b1;
      C_PC: PCout = 1'b1;     C_MDR: MDRout = 1'b1;
      C_IN: InPortout = 1'b1; C_Y: Yout = 1'b1;
      default: ;
    endcase
  endtask

  task automatic set_in(int c);
    if (c >= 0 && c < 16) rin[c] = 1'b1;
    case (c)
      C_HI: HIin = 1'b1;     C_LO: LOin = 1'b1;
      C_ZH: ZHighin = 1'b1;  C_ZL: Zlowin = 1'b1;
      C_PC: InPC = 1'b1;     C_MDR: MDRin = 1'b1;
      C_IN: InPortin = 1'b1; C_Y: Yin = 1'b1;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic xfer(int s, int d);
    logic [31:0] v;
    idle();
    set_out(s);
    set_in(d);
    v = (s < 0) ? 32'h0 : m[s];
    tick();
    m[d] = v;
  endtask

  task automatic load(int d, logic [31:0] v);
    idle();
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
    m[C_MDR] = v;
    if (d != C_MDR) xfer(C_MDR, d);
  endtask

  task automatic alu_step(int s, logic [4:0] o, logic zh_en, logic zl_en);
    logic [63:0] res;
    idle();
    set_out(s);
    op = o; ZHighin = zh_en; Zlowin = zl_en;
    res = ref_alu(m[C_Y], (s < 0) ? 32'h0 : m[s], o);
    tick();
    if (zh_en) m[C_ZH] = res[63:32];
    if (zl_en) m[C_ZL] = res[31:0];
  endtask

  task automatic test_reset();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 24; c++) begin
      m[c] = 32'h0;
      checks++;
      if (obs(c) !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d got %h exp 00000000", c, obs(c));
      end
    end
  endtask

  task automatic test_not();
    load(C_MDR, 32'hFFFFFFF4);
    checks++;
    if (mdrData !== 32'hFFFFFFF4) begin errors++; $display("FAIL not_mdr got %h exp fffffff4", mdrData); end
    xfer(C_MDR, C_Y);
    checks++;
    if (BusMuxInYout !== 32'hFFFFFFF4) begin errors++; $display("FAIL not_y got %h exp fffffff4", BusMuxInYout); end
    alu_step(-1, 5'b01000, 1'b1, 1'b1);
    checks++;
    if (BusMuxInZlow !== 32'h0000000B) begin errors++; $display("FAIL not_zlow got %h exp 0000000b", BusMuxInZlow); end
    checks++;
    if (BusMuxInZhigh !== 32'h0) begin errors++; $display("FAIL not_zhigh got %h exp 00000000", BusMuxInZhigh); end
    xfer(C_ZL, 6);
    checks++;
    if (bmr[6] !== 32'h0000000B) begin errors++; $display("FAIL not_r6 got %h exp 0000000b", bmr[6]); end
    load(0, 32'h55AA55AA);
    checks++;
    if (bmr[0] !== 32'h55AA55AA) begin errors++; $display("FAIL r0_load got %h exp 55aa55aa", bmr[0]); end
    xfer(C_ZH, 0);
    checks++;
    if (bmr[0] !== 32'h0) begin errors++; $display("FAIL not_r0 got %h exp 00000000", bmr[0]); end
  endtask

  task automatic test_add_sub();
    load(C_Y, 32'd5);
    load(2, 32'd7);
    alu_step(2, 5'b00001, 1'b1, 1'b1);
    checks++;
    if (BusMuxInZlow !== 32'd12) begin errors++; $display("FAIL add_zlow got %h exp 0000000c", BusMuxInZlow); end
    checks++;
    if (BusMuxInZhigh !== 32'h0) begin errors++; $display("FAIL add_zhigh got %h exp 00000000", BusMuxInZhigh); end
    alu_step(2, 5'b00010, 1'b1, 1'b1);
    checks++;
    if (BusMuxInZlow !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_zlow got %h exp fffffffe", BusMuxInZlow); end
    load(C_Y, 32'hFFFFFFFF);
    load(1, 32'd1);
    alu_step(1, 5'b00001, 1'b1, 1'b1);
    checks++;
    if (BusMuxInZlow !== 32'h0) begin errors++; $display("FAIL add_wrap got %h exp 00000000", BusMuxInZlow); end
  endtask

  task automatic test_mul_div();
    load(C_Y, 32'hFFFFFFFD);
    load(4, 32'h40000000);
    alu_step(4, 5'b01100, 1'b1, 1'b1);
    checks++;
    if ({BusMuxInZhigh, BusMuxInZlow} !== 64'hFFFFFFFF_40000000) begin
      errors++; $display("FAIL mul got %h%h exp ffffffff40000000", BusMuxInZhigh, BusMuxInZlow);
    end
    load(C_Y, 32'hFFFFFFF9);
    load(4, 32'd2);
    alu_step(4, 5'b01101, 1'b1, 1'b1);
    checks++;
    if (BusMuxInZlow !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_quo got %h exp fffffffd", BusMuxInZlow); end
    checks++;
    if (BusMuxInZhigh !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_rem got %h exp ffffffff", BusMuxInZhigh); end
    load(4, 32'd0);
    alu_step(4, 5'b01101, 1'b1, 1'b1);
    checks++;
    if ({BusMuxInZhigh, BusMuxInZlow} !== 64'h0) begin
      errors++; $display("FAIL div_zero got %h%h exp 0000000000000000", BusMuxInZhigh, BusMuxInZlow);
    end
  endtask

  task automatic test_shift();
    logic [4:0]  ops [6] = '{5'b00101, 5'b00110, 5'b01011, 5'b01010, 5'b00111, 5'b00101};
    logic [31:0] bs  [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd33};
    logic [31:0] exp [6] = '{32'h40000000, 32'hC0000000, 32'h00000003,
                             32'hC0000000, 32'h00000002, 32'h40000000};
    load(C_Y, 32'h80000001);
    for (int i = 0; i < 6; i++) begin
      load(4, bs[i]);
      alu_step(4, ops[i], 1'b1, 1'b1);
      checks++;
      if (BusMuxInZlow !== exp[i] || BusMuxInZhigh !== 32'h0) begin
        errors++;
        $display("FAIL shift%0d got %h_%h exp 00000000_%h", i, BusMuxInZhigh, BusMuxInZlow, exp[i]);
      end
    end
  endtask

  task automatic test_bus();
    load(3, 32'hA5A50003);
    load(C_PC, 32'h00000100);
    load(C_Y, 32'h0000BEEF);
    idle();
    #1;
    checks++;
    if (BusOut !== 32'h0) begin errors++; $display("FAIL bus_none got %h exp 00000000", BusOut); end
    rout[3] = 1'b1; PCout = 1'b1;
    #1;
    checks++;
    if (BusOut !== 32'hA5A50003) begin errors++; $display("FAIL bus_r3_pc got %h exp a5a50003", BusOut); end
    idle();
    PCout = 1'b1; Yout = 1'b1;
    #1;
    checks++;
    if (BusOut !== 32'h00000100) begin errors++; $display("FAIL bus_pc_y got %h exp 00000100", BusOut); end
    tick();
    xfer(3, C_MDR);
    checks++;
    if (mdrData !== 32'hA5A50003) begin errors++; $display("FAIL mdr_from_bus got %h exp a5a50003", mdrData); end
  endtask

  task automatic test_random();
    int s, d, d2, a;
    logic [4:0] o;
    for (int c = 0; c < 24; c++) begin
      if (c != C_ZH && c != C_ZL) load(c, $urandom);
    end
    for (int it = 0; it < 150; it++) begin
      a = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 24)) - 1;
      d = int'($urandom_range(0, 21));
      if (d >= 18) d = d + 2;
      d2 = int'($urandom_range(0, 21));
      if (d2 >= 18) d2 = d2 + 2;
      if (a == 0) begin
        idle();
        set_out(s); set_in(d); set_in(d2);
        #1;
        checks++;
        if (BusOut !== ((s < 0) ? 32'h0 : m[s])) begin
          errors++; $display("FAIL rand_bus it%0d got %h exp %h", it, BusOut, (s < 0) ? 32'h0 : m[s]);
        end
        xfer(s, d);
        if (d2 != d) xfer(s, d2);
      end else if (a == 1) begin
        load(d, $urandom);
      end else begin
        o = 5'($urandom_range(0, 15));
        if (o == 5'd13 && m[C_Y] == 32'h80000000 && s >= 0 && m[s] == 32'hFFFFFFFF) o = 5'd1;
        alu_step(s, o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int c = 0; c < 24; c++) begin
        checks++;
        if (obs(c) !== m[c]) begin
          errors++; $display("FAIL rand_reg%0d it%0d got %h exp %h", c, it, obs(c), m[c]);
        end
      end
    end
  endtask

  task automatic test_reset_priority();
    load(5, 32'h00001234);
    checks++;
    if (bmr[5] !== 32'h00001234) begin errors++; $display("FAIL r5_load got %h exp 00001234", bmr[5]); end
    load(C_Y, 32'h00000077);
    idle();
    clear = 1'b1;
    rout[5] = 1'b1; rin = 16'hFFFF;
    {HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin} = '1;
    Read = 1'b1; Mdatain = 32'hFFFFFFFF; op = 5'b00001;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs(c) !== 32'h0) begin
        errors++; $display("FAIL clear_reg%0d got %h exp 00000000", c, obs(c));
      end
    end
  endtask

  initial begin
    clear = 1'b0;
    Mdatain = '0;
    idle();
    test_reset();
    test_not();
    test_add_sub();
    test_mul_div();
    test_shift();
    test_bus();
    test_random();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus CPU datapath.
- Contains 16 general registers R0–R15, HI, LO, PC, InPort, Y, a 64-bit Z (Zhigh/Zlow), MDR, a one-hot-selected bus multiplexer and a combinational ALU.
- The external control unit (or a bench) drives per-register out/in strobes and a 5-bit ALU opcode.
- Every register value is exported for observation.

Parameters:
- DATA_W, 32, datapath/bus width. Fixed; other values unsupported.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset.
- Read  in  1  MDR source select: 1 = Mdatain, 0 = BusOut.
- op  in  5  ALU opcode.
- Mdatain  in  32  memory data input.
- R0out..R15out, HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout  in  1 each  bus-drive selects.
- R0in..R15in, HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin  in  1 each  register load enables.
- BusOut  out  32  current bus value.
- mdrData  out  32  MDR contents.
- BusMuxInR0..BusMuxInR15, BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO  out  32 each  register contents.

Interface note:
- One clock; reset is synchronous and active-high.
- Clock port is Clock; reset port is clear.

Behaviour:

Reset:
- clear=1 at a rising edge zeroes every register: R0–R15, HI, LO, PC, InPort, Y, Zhigh, Zlow, MDR.
- clear has priority over all load enables.

Bus:
- Combinational.
- Exactly one out-select is intended to be active at a time.
- If several are active, fixed priority applies: R0 > … > R15 > HI > LO > Zhigh > Zlow > PC > MDR > InPort > Y.
- No select active → BusOut = 0.

Register loads:
- On a rising edge with the xin enable high, the register loads BusOut.
- R0 is an ordinary register; it is not hardwired to zero.
- InPC loads PC. InPortin loads InPort from BusOut.
- MDRin loads Mdatain when Read=1, else BusOut.

ALU:
- Combinational, no latency. A = Y, B = BusOut, 64-bit result {hi, lo}.
- Opcodes:
  - 00001 ADD: lo = A+B (wraps mod 2^32), hi = 0.
  - 00010 SUB: lo = A−B, hi = 0.
  - 00011 AND: lo = A&B, hi = 0.
  - 00100 OR: lo = A|B, hi = 0.
  - 00101 SHR: logical right shift of A by B[4:0].
  - 00110 SHRA: arithmetic right shift of A by B[4:0].
  - 00111 SHL: left shift of A by B[4:0].
  - 01000 NOT: lo = ~A (unary on Y; bus ignored), hi = 0.
  - 01001 NEG: lo = −A (two's complement), hi = 0.
  - 01010 ROR: rotate A right by B[4:0].
  - 01011 ROL: rotate A left by B[4:0].
  - 01100 MUL: signed A×B, full 64-bit {hi, lo}.
  - 01101 DIV: signed; lo = quotient truncated toward zero, hi = remainder with sign of A. B=0 → hi = lo = 0.
  - All other codes (including 00000): result 0.
  - For ops not listed with their own hi value (shifts, rotates), hi = 0.
- ZHighin loads Zhigh ← hi; Zlowin loads Zlow ← lo. The two are independent and may load in the same cycle.

Timing:
- Typical operation: source on bus and destination enable asserted within the same cycle; the value is visible on BusMuxIn* after that edge.
- Y must be loaded at least one cycle before the ALU operation.

Decomposition:
- Shared package data_path_pkg holds the ALU opcode localparams (OP_ADD … OP_DIV) and DATA_W.
- Sub-module alu: inputs a, b, op; output result[63:0].
- Registers and the bus mux stay inline in data_path.

Test Plan:
- NOT:
  - Mdatain = −12 (0xFFFFFFF4), Read=1, MDRin → mdrData = 0xFFFFFFF4.
  - MDRout+Yin → Y = 0xFFFFFFF4.
  - op = 01000 with ZHighin+Zlowin → Zlow = 0x0000000B, Zhigh = 0.
  - Zlowout+R6in → R6 = 0x0000000B; Zhighout+R0in → R0 = 0.
- ADD / SUB:
  - Y = 5, R2 = 7 on bus, op = 00001 → Zlow = 12.
  - op = 00010 → Zlow = 0xFFFFFFFE.
  - Y = 0xFFFFFFFF, B = 1, ADD → Zlow = 0 (wrap).
- MUL / DIV:
  - Y = −3, B = 0x40000000, MUL → {Zhigh, Zlow} = 0xFFFFFFFF_40000000.
  - Y = −7, B = 2, DIV → Zlow = −3, Zhigh = −1.
  - B = 0, DIV → both 0.
- Shifts / rotates (Y = 0x80000001, B = 1):
  - SHR → 0x40000000.
  - SHRA → 0xC0000000.
  - ROL → 0x00000003.
  - ROR → 0xC0000000.
- Bus: no out-select → BusOut = 0; R3out and PCout together → BusOut = R3.
- Reset: load R5 = 0x1234, then clear=1 for one edge → all BusMuxIn* and mdrData read 0, including when R5in is high during that edge.
